tx_os_scheduler: RTL and testbench
==================================

# tx_os_scheduler

Sequencer for the shared transmit datapath mux. It decides, cycle by cycle, whether lanes carry LPIF FIFO data or an ordered set from the OS generator. It inserts periodic SKP ordered sets at packet boundaries, services LTSSM-requested ordered sets with priority, and drives FIFO hold, mux select and OS-generator start. It sits between TX_LTSSM / TX_CONTROL and the OS_GENERATOR / MUX pair.

## Interface
Parameters:
- SKP_INTERVAL, 1180: cycles between SKP requests while enabled (≥ 8).
- MAX_PENDING, 4: saturation limit of owed SKP count (1..7).
- OS_TIMEOUT, 255: cycles to wait for os_finish before abort.

Ports:
- pclk  in  1  transmit clock; only clock in the block.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  link in L0; SKP scheduling active.
- pkt_active  in  1  TLP/DLP in flight (start seen, end not yet).
- ltssm_os_req  in  1  level request for one LTSSM ordered set.
- ltssm_os_type  in  3  OS type for ltssm_os_req; stable while req high.
- ltssm_os_ack  out  1  one-cycle pulse, LTSSM OS complete.
- os_start  out  1  one-cycle start pulse to OS generator.
- os_type  out  3  OS type presented with os_start; held until finish.
- os_finish  in  1  OS generator completion pulse.
- fifo_hold  out  1  stall LPIF FIFO output.
- mux_sel  out  1  0 = FIFO path, 1 = OS path.
- skp_pending  out  3  owed SKP count.
- skp_overflow  out  1  sticky; a SKP request was dropped at saturation.
- os_timeout_err  out  1  sticky; os_finish missed.

## Operation
- Interval counter: increments each cycle while enable=1; cleared while enable=0. At SKP_INTERVAL-1 it wraps to 0 and skp_pending increments. At MAX_PENDING the increment is dropped and skp_overflow is set. The counter keeps running during insertion.
- skp_pending decrements on each os_finish of a SKP issue. A simultaneous increment and decrement leaves it unchanged. enable=0 clears skp_pending.
- FSM states:
  - DATA: mux_sel=0, hold=0. Exits to HOLD when pkt_active=0 and either ltssm_os_req=1 or (skp_pending>0 and enable=1).
  - HOLD: hold=1, mux_sel=0, one cycle so the FIFO pipeline drains. Then goes to ISSUE.
  - ISSUE: hold=1, mux_sel=1, os_start=1 for one cycle. os_type latched: LTSSM type if ltssm_os_req, else OS_SKP. Then goes to WAIT.
  - WAIT: hold=1, mux_sel=1.
    - On os_finish: if the issue was LTSSM, pulse ltssm_os_ack next cycle. Then, if ltssm_os_req is still pending, or (skp_pending after decrement >0 and enable=1), go to ISSUE (back-to-back, no FIFO gap). Otherwise go to DATA.
    - If the timeout counter reaches OS_TIMEOUT: set os_timeout_err and go to DATA. Pending is unchanged and no ack is issued.
- Priority: LTSSM request beats SKP when both are ready in the same cycle.
- enable falling mid-insertion: the current OS completes. Pending is cleared, so the FSM returns to DATA after finish unless an LTSSM request is present.
- pkt_active rising while in HOLD/ISSUE/WAIT is ignored; the FIFO is already held.

## Timing
- Reset values: all outputs 0, os_type=0, FSM=DATA, counters 0, sticky flags cleared.
- Request to os_start latency: 2 cycles when pkt_active=0. The decision is registered in DATA, then HOLD, then ISSUE.
- os_finish to mux_sel=0 / fifo_hold=0: next cycle. os_finish to back-to-back os_start: next cycle.
- ltssm_os_ack rises one cycle after the os_finish that completes an LTSSM issue.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package tx_pkg holds:
  - OS type constants (OS_TS1=0, OS_TS2=1, OS_EIOS=2, OS_SKP=3, OS_EIEOS=4, OS_FTS=5).
  - The FSM state enum.
- Sub-module tx_skp_timer: interval counter plus pending/overflow logic.

## Test plan
- SKP_INTERVAL=16, enable=1, pkt_active=0 → skp_pending=1 at cycle 16, os_start with os_type=3 two cycles later, mux_sel returns 0 the cycle after os_finish.
- pkt_active=1 for 60 cycles, SKP_INTERVAL=16, MAX_PENDING=4 → skp_pending saturates at 3 without overflow; after pkt_active falls, 3 back-to-back SKP starts with fifo_hold continuously high.
- pkt_active=1 for 100 cycles, SKP_INTERVAL=16, MAX_PENDING=4 → skp_pending saturates at 4; skp_overflow=1 and stays 1.
- ltssm_os_req (type 2) and SKP pending in the same cycle → EIOS issued first, ltssm_os_ack one cycle after its finish, SKP immediately following.
- os_finish withheld, OS_TIMEOUT=8 → os_timeout_err=1, mux_sel=0 and fifo_hold=0, skp_pending unchanged.
- reset asserted during WAIT → next edge: all outputs 0, FSM=DATA, skp_pending=0.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared transmit-path definitions: ordered-set type codes and the scheduler FSM state.
package tx_pkg;

    localparam logic [2:0] OS_TS1   = 3'd0;
    localparam logic [2:0] OS_TS2   = 3'd1;
    localparam logic [2:0] OS_EIOS  = 3'd2;
    localparam logic [2:0] OS_SKP   = 3'd3;
    localparam logic [2:0] OS_EIEOS = 3'd4;
    localparam logic [2:0] OS_FTS   = 3'd5;

    typedef enum logic [1:0] {
        ST_DATA  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/tx_os_scheduler_if.sv
// Control/handshake bundle between the OS scheduler and its LTSSM, OS generator and mux neighbours.
interface tx_os_scheduler_if;

    logic       enable;
    logic       pkt_active;
    logic       ltssm_os_req;
    logic [2:0] ltssm_os_type;
    logic       ltssm_os_ack;
    logic       os_start;
    logic [2:0] os_type;
    logic       os_finish;
    logic       fifo_hold;
    logic       mux_sel;
    logic [2:0] skp_pending;
    logic       skp_overflow;
    logic       os_timeout_err;

    modport slave (
        input  enable, pkt_active, ltssm_os_req, ltssm_os_type, os_finish,
        output ltssm_os_ack, os_start, os_type, fifo_hold, mux_sel,
               skp_pending, skp_overflow, os_timeout_err
    );

    modport master (
        output enable, pkt_active, ltssm_os_req, ltssm_os_type, os_finish,
        input  ltssm_os_ack, os_start, os_type, fifo_hold, mux_sel,
               skp_pending, skp_overflow, os_timeout_err
    );

endinterface

// File: rtl/tx_skp_timer.sv
// SKP interval counter with a saturating count of owed SKP ordered sets.
module tx_skp_timer
    import tx_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned MAX_PENDING  = 4
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       enable,
    input  logic       skp_done,
    output logic [2:0] skp_pending,
    output logic       skp_overflow
);

    localparam int unsigned CNT_W    = $clog2(SKP_INTERVAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [2:0] PEND_MAX  = 3'(MAX_PENDING);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_LAST);

    always_ff @(posedge pclk) begin
        if (reset) begin
            cnt          <= '0;
            skp_pending  <= '0;
            skp_overflow <= 1'b0;
        end else if (!enable) begin
            cnt         <= '0;
            skp_pending <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            // A request and a completion in the same cycle cancel out.
            if (wrap && !skp_done) begin
                if (skp_pending == PEND_MAX)
                    skp_overflow <= 1'b1;
                else
                    skp_pending <= skp_pending + 3'd1;
            end else if (!wrap && skp_done && skp_pending != 3'd0) begin
                skp_pending <= skp_pending - 3'd1;
            end
        end
    end

endmodule

// File: rtl/tx_os_scheduler.sv
// Chooses FIFO data or ordered sets for the shared TX mux; LTSSM requests beat periodic SKPs.
module tx_os_scheduler
    import tx_pkg::*;
#(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned MAX_PENDING  = 4,
    parameter int unsigned OS_TIMEOUT   = 255
) (
    input  logic              pclk,
    input  logic              reset,
    tx_os_scheduler_if.slave  bus
);

    localparam int unsigned TO_W = $clog2(OS_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(OS_TIMEOUT - 1);

    sched_state_t    state;
    logic [TO_W-1:0] tcnt;
    logic            issue_ltssm;
    logic            os_start;
    logic [2:0]      os_type;
    logic            ltssm_os_ack;
    logic            fifo_hold;
    logic            mux_sel;
    logic            os_timeout_err;
    logic [2:0]      skp_pending;
    logic            skp_overflow;

    logic            skp_done;
    logic            ltssm_live;
    logic            skp_ready;
    logic            more_ltssm;
    logic            more_skp;
    logic [2:0]      pend_left;

    tx_skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .MAX_PENDING  (MAX_PENDING)
    ) u_skp_timer (
        .pclk         (pclk),
        .reset        (reset),
        .enable       (bus.enable),
        .skp_done     (skp_done),
        .skp_pending  (skp_pending),
        .skp_overflow (skp_overflow)
    );

    always_comb begin
        skp_done   = (state == ST_WAIT) && bus.os_finish && !issue_ltssm;
        // A request still high while its ack is out belongs to the OS just completed.
        ltssm_live = bus.ltssm_os_req && !ltssm_os_ack;
        skp_ready  = bus.enable && (skp_pending != 3'd0);
        more_ltssm = ltssm_live && !issue_ltssm;
        pend_left  = skp_pending;
        if (!issue_ltssm && skp_pending != 3'd0)
            pend_left = skp_pending - 3'd1;
        more_skp   = bus.enable && (pend_left != 3'd0);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state          <= ST_DATA;
            tcnt           <= '0;
            issue_ltssm    <= 1'b0;
            os_start       <= 1'b0;
            os_type        <= 3'd0;
            ltssm_os_ack   <= 1'b0;
            fifo_hold      <= 1'b0;
            mux_sel        <= 1'b0;
            os_timeout_err <= 1'b0;
        end else begin
            os_start     <= 1'b0;
            ltssm_os_ack <= 1'b0;
            case (state)
                ST_DATA: begin
                    if (!bus.pkt_active && (ltssm_live || skp_ready)) begin
                        state     <= ST_HOLD;
                        fifo_hold <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (ltssm_live || skp_ready) begin
                        state       <= ST_ISSUE;
                        mux_sel     <= 1'b1;
                        os_start    <= 1'b1;
                        issue_ltssm <= ltssm_live;
                        os_type     <= ltssm_live ? bus.ltssm_os_type : OS_SKP;
                    end else begin
                        state     <= ST_DATA;
                        fifo_hold <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                    tcnt  <= '0;
                end
                ST_WAIT: begin
                    if (bus.os_finish) begin
                        ltssm_os_ack <= issue_ltssm;
                        if (more_ltssm || more_skp) begin
                            state       <= ST_ISSUE;
                            os_start    <= 1'b1;
                            issue_ltssm <= more_ltssm;
                            os_type     <= more_ltssm ? bus.ltssm_os_type : OS_SKP;
                        end else begin
                            state     <= ST_DATA;
                            fifo_hold <= 1'b0;
                            mux_sel   <= 1'b0;
                        end
                    end else if (tcnt == TO_LAST) begin
                        os_timeout_err <= 1'b1;
                        state          <= ST_DATA;
                        fifo_hold      <= 1'b0;
                        mux_sel        <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= ST_DATA;
            endcase
        end
    end

    assign bus.os_start       = os_start;
    assign bus.os_type        = os_type;
    assign bus.ltssm_os_ack   = ltssm_os_ack;
    assign bus.fifo_hold      = fifo_hold;
    assign bus.mux_sel        = mux_sel;
    assign bus.skp_pending    = skp_pending;
    assign bus.skp_overflow   = skp_overflow;
    assign bus.os_timeout_err = os_timeout_err;

endmodule

// File: tb/tb_tx_os_scheduler.sv
// Directed bench for tx_os_scheduler with SKP_INTERVAL=16, MAX_PENDING=4, OS_TIMEOUT=8.
module tb_tx_os_scheduler;

    logic pclk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 pclk = ~pclk;

    tx_os_scheduler_if bus ();

    tx_os_scheduler #(
        .SKP_INTERVAL (16),
        .MAX_PENDING  (4),
        .OS_TIMEOUT   (8)
    ) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_start"}, 8'(bus.os_start), 8'd0);
        check({tag, "_type"},  8'(bus.os_type), 8'd0);
        check({tag, "_ack"},   8'(bus.ltssm_os_ack), 8'd0);
        check({tag, "_hold"},  8'(bus.fifo_hold), 8'd0);
        check({tag, "_mux"},   8'(bus.mux_sel), 8'd0);
        check({tag, "_pend"},  8'(bus.skp_pending), 8'd0);
        check({tag, "_ovf"},   8'(bus.skp_overflow), 8'd0);
        check({tag, "_terr"},  8'(bus.os_timeout_err), 8'd0);
    endtask

    initial begin
        reset             = 1'b1;
        bus.enable        = 1'b0;
        bus.pkt_active    = 1'b0;
        bus.ltssm_os_req  = 1'b0;
        bus.ltssm_os_type = 3'd0;
        bus.os_finish     = 1'b0;
        tick();
        tick();
        check_idle("reset");

        // Edge count n below is measured from reset release.
        reset      = 1'b0;
        bus.enable = 1'b1;
        repeat (15) tick();
        check("pend_before_16", 8'(bus.skp_pending), 8'd0);
        tick();                                     // n=16
        check("pend_at_16", 8'(bus.skp_pending), 8'd1);
        check("no_start_16", 8'(bus.os_start), 8'd0);
        tick();                                     // n=17 HOLD
        check("hold_17", 8'(bus.fifo_hold), 8'd1);
        check("mux_17", 8'(bus.mux_sel), 8'd0);
        tick();                                     // n=18 ISSUE
        check("start_18", 8'(bus.os_start), 8'd1);
        check("type_18", 8'(bus.os_type), 8'd3);
        check("mux_18", 8'(bus.mux_sel), 8'd1);
        tick();                                     // n=19 WAIT
        check("start_19", 8'(bus.os_start), 8'd0);
        bus.os_finish = 1'b1;
        tick();                                     // n=20 back to DATA
        bus.os_finish = 1'b0;
        check("mux_20", 8'(bus.mux_sel), 8'd0);
        check("hold_20", 8'(bus.fifo_hold), 8'd0);
        check("pend_20", 8'(bus.skp_pending), 8'd0);
        check("ack_20", 8'(bus.ltssm_os_ack), 8'd0);

        // LTSSM EIOS and a new SKP become ready together at n=33.
        repeat (12) tick();                         // n=32
        check("pend_32", 8'(bus.skp_pending), 8'd1);
        bus.ltssm_os_req  = 1'b1;
        bus.ltssm_os_type = 3'd2;
        tick();                                     // n=33 HOLD
        check("hold_33", 8'(bus.fifo_hold), 8'd1);
        tick();                                     // n=34 ISSUE EIOS
        check("start_34", 8'(bus.os_start), 8'd1);
        check("type_34", 8'(bus.os_type), 8'd2);
        tick();                                     // n=35 WAIT
        bus.os_finish = 1'b1;
        tick();                                     // n=36 ack + SKP issue
        bus.os_finish    = 1'b0;
        check("ack_36", 8'(bus.ltssm_os_ack), 8'd1);
        bus.ltssm_os_req = 1'b0;
        check("start_36", 8'(bus.os_start), 8'd1);
        check("type_36", 8'(bus.os_type), 8'd3);
        check("hold_36", 8'(bus.fifo_hold), 8'd1);
        check("pend_36", 8'(bus.skp_pending), 8'd1);
        tick();                                     // n=37 WAIT
        check("ack_37", 8'(bus.ltssm_os_ack), 8'd0);
        bus.os_finish = 1'b1;
        tick();                                     // n=38 DATA
        bus.os_finish = 1'b0;
        check("mux_38", 8'(bus.mux_sel), 8'd0);
        check("pend_38", 8'(bus.skp_pending), 8'd0);

        // Packet in flight: increments at n=48,64,80.
        bus.pkt_active = 1'b1;
        repeat (46) tick();                         // n=84
        check("pend_84", 8'(bus.skp_pending), 8'd3);
        check("ovf_84", 8'(bus.skp_overflow), 8'd0);
        check("hold_84", 8'(bus.fifo_hold), 8'd0);
        bus.pkt_active = 1'b0;
        tick();                                     // n=85 HOLD
        check("hold_85", 8'(bus.fifo_hold), 8'd1);
        tick();                                     // n=86 ISSUE #1
        check("b2b_start_86", 8'(bus.os_start), 8'd1);
        check("b2b_type_86", 8'(bus.os_type), 8'd3);
        for (int k = 0; k < 3; k++) begin
            tick();                                 // WAIT
            check("b2b_wait_start", 8'(bus.os_start), 8'd0);
            check("b2b_wait_hold", 8'(bus.fifo_hold), 8'd1);
            check("b2b_wait_mux", 8'(bus.mux_sel), 8'd1);
            bus.os_finish = 1'b1;
            tick();
            bus.os_finish = 1'b0;
            if (k < 2) begin
                check("b2b_restart", 8'(bus.os_start), 8'd1);
                check("b2b_hold", 8'(bus.fifo_hold), 8'd1);
                check("b2b_pend", 8'(bus.skp_pending), 8'(2 - k));
            end else begin
                check("b2b_end_hold", 8'(bus.fifo_hold), 8'd0);
                check("b2b_end_mux", 8'(bus.mux_sel), 8'd0);
                check("b2b_end_pend", 8'(bus.skp_pending), 8'd0);
            end
        end

        // Long packet: increments at n=96,112,128,144; dropped at n=160.
        bus.pkt_active = 1'b1;
        repeat (67) tick();                         // n=159
        check("pend_159", 8'(bus.skp_pending), 8'd4);
        check("ovf_159", 8'(bus.skp_overflow), 8'd0);
        tick();                                     // n=160
        check("pend_160", 8'(bus.skp_pending), 8'd4);
        check("ovf_160", 8'(bus.skp_overflow), 8'd1);
        repeat (3) tick();
        check("ovf_sticky", 8'(bus.skp_overflow), 8'd1);
        bus.enable = 1'b0;
        tick();
        check("pend_disable", 8'(bus.skp_pending), 8'd0);
        check("ovf_disable", 8'(bus.skp_overflow), 8'd1);

        // Timeout: restart from reset with os_finish withheld.
        reset          = 1'b1;
        bus.pkt_active = 1'b0;
        tick();
        check_idle("reset2");
        reset      = 1'b0;
        bus.enable = 1'b1;
        repeat (16) tick();
        check("to_pend_16", 8'(bus.skp_pending), 8'd1);
        repeat (2) tick();                          // n=18 ISSUE
        check("to_start_18", 8'(bus.os_start), 8'd1);
        repeat (8) tick();                          // n=26
        check("to_mux_26", 8'(bus.mux_sel), 8'd1);
        check("to_err_26", 8'(bus.os_timeout_err), 8'd0);
        tick();                                     // n=27
        check("to_err_27", 8'(bus.os_timeout_err), 8'd1);
        check("to_mux_27", 8'(bus.mux_sel), 8'd0);
        check("to_hold_27", 8'(bus.fifo_hold), 8'd0);
        check("to_pend_27", 8'(bus.skp_pending), 8'd1);
        check("to_ack_27", 8'(bus.ltssm_os_ack), 8'd0);
        repeat (3) tick();                          // n=30 WAIT again
        check("rw_mux_30", 8'(bus.mux_sel), 8'd1);
        check("rw_hold_30", 8'(bus.fifo_hold), 8'd1);

        // Reset while waiting for the generator.
        reset = 1'b1;
        tick();
        check_idle("reset_wait");
        reset      = 1'b0;
        bus.enable = 1'b0;
        tick();
        check("post_reset_hold", 8'(bus.fifo_hold), 8'd0);
        check("post_reset_mux", 8'(bus.mux_sel), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
